// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 job scheduler: host opcodes, controller state
// encoding and the layout of the 32-bit status word read back over SPI.
package md5_pkg;

  // Host opcodes, carried in word[31:28].
  localparam logic [3:0] OP_LOAD_HASH = 4'h1;
  localparam logic [3:0] OP_SET_RANGE = 4'h2;
  localparam logic [3:0] OP_GO        = 4'h3;
  localparam logic [3:0] OP_ABORT     = 4'h4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRun   = 3'd2,
    StDone  = 3'd3,
    StFound = 3'd4
  } state_e;

  // Status word: {state[2:0], found, err, 3'b0, chunks_issued[23:0]}.
  localparam int unsigned STAT_STATE_LSB = 29;
  localparam int unsigned STAT_FOUND     = 28;
  localparam int unsigned STAT_ERR       = 27;
  localparam int unsigned CHUNKS_W       = 24;

  function automatic logic [31:0] pack_status(input state_e st, input logic found,
                                              input logic err,
                                              input logic [CHUNKS_W-1:0] chunks);
    logic [31:0] s;
    s                         = '0;
    s[STAT_STATE_LSB +: 3]    = st;
    s[STAT_FOUND]             = found;
    s[STAT_ERR]               = err;
    s[CHUNKS_W-1:0]           = chunks;
    return s;
  endfunction

endpackage

// File: rtl/md5_prio_pick.sv
// Lowest-index priority picker.
//   req   : request vector
//   grant : one-hot of the lowest set bit of req (zero when req is zero)
//   idx   : binary index of that bit
//   any   : at least one request is set
module md5_prio_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/md5_job_scheduler.sv
// Hands fixed-size keyspace chunks to a bank of MD5 cores from the host
// command stream, stops everything on the first match or range exhaustion.
//   clk, rst        : core clock, synchronous active-high reset
//   word_valid/in   : host command/data word strobe
//   target_hash     : hash broadcast to all cores
//   core_start/base : one-hot start pulse and chunk base index
//   core_abort      : one-cycle stop pulse to all cores
//   core_done/found : per-core completion / match pulses, core_found_idx slices
//   status_out, result_idx, has_matched : SPI readback
module md5_job_scheduler
  import md5_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned CHUNK_LOG2 = 16,
  parameter int unsigned IDX_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       word_valid,
  input  logic [31:0]                word_in,
  output logic [127:0]               target_hash,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [IDX_W-1:0]           core_base,
  output logic                       core_abort,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_found,
  input  logic [NUM_CORES*IDX_W-1:0] core_found_idx,
  output logic [31:0]                status_out,
  output logic [IDX_W-1:0]           result_idx,
  output logic                       has_matched
);

  localparam int unsigned CoreIdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IDX_W:0] ChunkSize = (IDX_W+1)'(1) << CHUNK_LOG2;

  state_e                 state_q, state_d;
  logic                   load_hash_q, load_hash_d;
  logic [1:0]             load_cnt_q, load_cnt_d;
  logic [127:0]           hash_q, hash_d;
  logic [IDX_W-1:0]       start_q, start_d, end_q, end_d, base_q, base_d;
  logic [IDX_W-1:0]       result_q, result_d;
  logic [NUM_CORES-1:0]   assigned_q, assigned_d;
  logic                   disp_en_q, disp_en_d, found_q, found_d, err_q, err_d;
  logic                   abort_q, abort_d;
  logic [CHUNKS_W-1:0]    chunks_q, chunks_d;

  logic [NUM_CORES-1:0]   idle_grant, unused_found_grant;
  logic [CoreIdxW-1:0]    unused_idle_idx, found_idx;
  logic                   idle_any, found_any;
  logic [3:0]             opcode;
  logic                   load_last, dispatch, abort_cmd;
  logic [IDX_W:0]         base_sum;

  assign opcode    = word_in[31:28];
  assign abort_cmd = word_valid && (opcode == OP_ABORT);
  assign load_last = load_hash_q ? (load_cnt_q == 2'd3) : (load_cnt_q == 2'd1);
  assign base_sum  = {1'b0, base_q} + ChunkSize;

  md5_prio_pick #(.N(NUM_CORES), .IdxW(CoreIdxW)) u_idle_pick (
    .req   (~assigned_q),
    .grant (idle_grant),
    .idx   (unused_idle_idx),
    .any   (idle_any)
  );

  md5_prio_pick #(.N(NUM_CORES), .IdxW(CoreIdxW)) u_found_pick (
    .req   (core_found),
    .grant (unused_found_grant),
    .idx   (found_idx),
    .any   (found_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StFound: begin
        if (word_valid) begin
          case (opcode)
            OP_LOAD_HASH, OP_SET_RANGE: state_d = StLoad;
            OP_GO:    state_d = (start_q > end_q) ? StDone : StRun;
            OP_ABORT: state_d = StIdle;
            default:  state_d = state_q;
          endcase
        end
      end
      StLoad: if (word_valid && load_last) state_d = StIdle;
      StRun: begin
        // A match outranks abort and completion arriving in the same cycle.
        if (found_any)                           state_d = StFound;
        else if (abort_cmd)                      state_d = StIdle;
        else if (!disp_en_d && assigned_d == '0) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: dispatch is combinational so GO reaches a core one cycle later.
  always_comb begin
    dispatch   = (state_q == StRun) && disp_en_q && idle_any && !found_any && !abort_cmd;
    core_start = dispatch ? idle_grant : '0;
    core_base  = dispatch ? base_q : '0;
  end

  // Datapath next-state.
  always_comb begin
    load_hash_d = load_hash_q;
    load_cnt_d  = load_cnt_q;
    hash_d      = hash_q;
    start_d     = start_q;
    end_d       = end_q;
    base_d      = base_q;
    result_d    = result_q;
    assigned_d  = assigned_q;
    disp_en_d   = disp_en_q;
    found_d     = found_q;
    err_d       = err_q;
    abort_d     = 1'b0;
    chunks_d    = chunks_q;
    case (state_q)
      StIdle, StDone, StFound: begin
        if (word_valid) begin
          case (opcode)
            OP_LOAD_HASH: begin load_hash_d = 1'b1; load_cnt_d = '0; end
            OP_SET_RANGE: begin load_hash_d = 1'b0; load_cnt_d = '0; end
            OP_GO: begin
              base_d     = start_q;
              found_d    = 1'b0;
              err_d      = 1'b0;
              chunks_d   = '0;
              assigned_d = '0;
              disp_en_d  = (start_q <= end_q);
            end
            OP_ABORT: abort_d = 1'b1;
            default:  err_d   = 1'b1;
          endcase
        end
      end
      StLoad: begin
        if (word_valid) begin
          load_cnt_d = load_cnt_q + 2'd1;
          if (load_hash_q)            hash_d  = {hash_q[95:0], word_in};
          else if (load_cnt_q == '0)  start_d = IDX_W'(word_in);
          else                        end_d   = IDX_W'(word_in);
        end
      end
      StRun: begin
        assigned_d = assigned_q & ~core_done;
        if (abort_cmd) begin
          abort_d    = 1'b1;
          assigned_d = '0;
          disp_en_d  = 1'b0;
        end else if (word_valid) begin
          err_d = 1'b1;
        end
        if (found_any) begin
          result_d   = core_found_idx[int'(found_idx)*IDX_W +: IDX_W];
          found_d    = 1'b1;
          abort_d    = 1'b1;
          assigned_d = '0;
          disp_en_d  = 1'b0;
        end else if (dispatch) begin
          assigned_d = assigned_d | idle_grant;
          chunks_d   = chunks_q + 1'b1;
          // Stop once this chunk reaches end_idx or the base would wrap.
          if (base_sum > {1'b0, end_q}) disp_en_d = 1'b0;
          else                          base_d    = base_sum[IDX_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_hash_q <= 1'b0;
      load_cnt_q  <= '0;
      hash_q      <= '0;
      start_q     <= '0;
      end_q       <= '0;
      base_q      <= '0;
      result_q    <= '0;
      assigned_q  <= '0;
      disp_en_q   <= 1'b0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      chunks_q    <= '0;
    end else begin
      load_hash_q <= load_hash_d;
      load_cnt_q  <= load_cnt_d;
      hash_q      <= hash_d;
      start_q     <= start_d;
      end_q       <= end_d;
      base_q      <= base_d;
      result_q    <= result_d;
      assigned_q  <= assigned_d;
      disp_en_q   <= disp_en_d;
      found_q     <= found_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      chunks_q    <= chunks_d;
    end
  end

  assign target_hash = hash_q;
  assign core_abort  = abort_q;
  assign result_idx  = result_q;
  assign has_matched = found_q;
  assign status_out  = pack_status(state_q, found_q, err_q, chunks_q);

endmodule

// File: tb/tb_md5_job_scheduler.sv
// Directed bench for md5_job_scheduler with 4 cores, 64K-index chunks.
module tb_md5_job_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         word_valid;
  logic [31:0]  word_in;
  logic [127:0] target_hash;
  logic [3:0]   core_start;
  logic [31:0]  core_base;
  logic         core_abort;
  logic [3:0]   core_done;
  logic [3:0]   core_found;
  logic [127:0] core_found_idx;
  logic [31:0]  status_out;
  logic [31:0]  result_idx;
  logic         has_matched;

  int total = 0;
  int bad   = 0;

  md5_job_scheduler #(.NUM_CORES(4), .CHUNK_LOG2(16), .IDX_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .word_valid     (word_valid),
    .word_in        (word_in),
    .target_hash    (target_hash),
    .core_start     (core_start),
    .core_base      (core_base),
    .core_abort     (core_abort),
    .core_done      (core_done),
    .core_found     (core_found),
    .core_found_idx (core_found_idx),
    .status_out     (status_out),
    .result_idx     (result_idx),
    .has_matched    (has_matched)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    word_valid = 1'b1;
    word_in    = w;
    tick();
    word_valid = 1'b0;
    word_in    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (status_out !== 32'h0) begin bad++;
      $display("FAIL reset_status got %h want 00000000", status_out); end
    total++; if (target_hash !== 128'h0) begin bad++;
      $display("FAIL reset_hash got %h want 0", target_hash); end
    total++; if ({core_start, core_abort, has_matched} !== 6'b0) begin bad++;
      $display("FAIL reset_ctrl got %b want 000000", {core_start, core_abort, has_matched}); end
    total++; if (result_idx !== 32'h0) begin bad++;
      $display("FAIL reset_result got %h want 0", result_idx); end
  endtask

  task automatic test_bad_opcode();
    send(32'h7000_0000);
    total++; if (status_out !== 32'h0800_0000) begin bad++;
      $display("FAIL bad_opcode_status got %h want 08000000", status_out); end
  endtask

  task automatic test_load_hash();
    send(32'h1000_0000);
    total++; if (status_out[31:29] !== 3'd1) begin bad++;
      $display("FAIL load_state got %0d want 1", status_out[31:29]); end
    send(32'h0123_4567);
    send(32'h89ab_cdef);
    send(32'hfedc_ba98);
    send(32'h7654_3210);
    total++; if (target_hash !== 128'h0123456789abcdeffedcba9876543210) begin bad++;
      $display("FAIL load_hash got %h want 0123456789abcdeffedcba9876543210", target_hash); end
    total++; if (status_out[31:29] !== 3'd0) begin bad++;
      $display("FAIL load_back_idle got %0d want 0", status_out[31:29]); end
  endtask

  task automatic test_dispatch();
    logic [3:0]  exp_start;
    logic [31:0] exp_base;
    send(32'h2000_0000);
    send(32'h0000_0000);
    send(32'h0003_FFFF);
    send(32'h3000_0000);
    total++; if (status_out !== 32'h4000_0000) begin bad++;
      $display("FAIL go_status got %h want 40000000", status_out); end
    for (int i = 0; i < 4; i++) begin
      exp_start = 4'b0001 << i;
      exp_base  = 32'(i) << 16;
      total++; if (core_start !== exp_start || core_base !== exp_base) begin bad++;
        $display("FAIL dispatch_%0d got %b/%h want %b/%h", i, core_start, core_base,
                 exp_start, exp_base); end
      tick();
    end
    total++; if (core_start !== 4'b0) begin bad++;
      $display("FAIL dispatch_extra got %b want 0000", core_start); end
    core_done = 4'hF;
    tick();
    core_done = 4'h0;
    total++; if (status_out !== 32'h6000_0004) begin bad++;
      $display("FAIL dispatch_done got %h want 60000004", status_out); end
    total++; if (core_start !== 4'b0 || has_matched !== 1'b0) begin bad++;
      $display("FAIL dispatch_idle got %b/%b want 0000/0", core_start, has_matched); end
  endtask

  task automatic test_found();
    logic [3:0] exp_start;
    send(32'h3000_0000);
    for (int i = 0; i < 3; i++) begin
      exp_start = 4'b0001 << i;
      total++; if (core_start !== exp_start) begin bad++;
        $display("FAIL found_start_%0d got %b want %b", i, core_start, exp_start); end
      tick();
    end
    core_found              = 4'b0100;
    core_found_idx[64 +: 32] = 32'h0002_ABCD;
    #1;
    total++; if (core_start !== 4'b0) begin bad++;
      $display("FAIL found_no_dispatch got %b want 0000", core_start); end
    tick();
    core_found = 4'b0;
    total++; if (has_matched !== 1'b1 || core_abort !== 1'b1) begin bad++;
      $display("FAIL found_flags got %b%b want 11", has_matched, core_abort); end
    total++; if (result_idx !== 32'h0002_ABCD) begin bad++;
      $display("FAIL found_result got %h want 0002abcd", result_idx); end
    total++; if (status_out[31:27] !== 5'b10010) begin bad++;
      $display("FAIL found_state got %b want 10010", status_out[31:27]); end
    tick();
    total++; if (core_abort !== 1'b0 || core_start !== 4'b0) begin bad++;
      $display("FAIL found_after got %b/%b want 0/0000", core_abort, core_start); end
  endtask

  task automatic test_multi_found();
    send(32'h3000_0000);
    total++; if (has_matched !== 1'b0) begin bad++;
      $display("FAIL go_clears_found got %b want 0", has_matched); end
    core_found               = 4'b1010;
    core_found_idx[32 +: 32] = 32'h0000_0111;
    core_found_idx[96 +: 32] = 32'h0000_0333;
    #1;
    tick();
    core_found = 4'b0;
    total++; if (result_idx !== 32'h0000_0111 || has_matched !== 1'b1) begin bad++;
      $display("FAIL multi_found got %h/%b want 00000111/1", result_idx, has_matched); end
  endtask

  task automatic test_top_range();
    send(32'h2000_0000);
    send(32'hFFFF_0000);
    send(32'hFFFF_FFFF);
    send(32'h3000_0000);
    total++; if (core_start !== 4'b0001 || core_base !== 32'hFFFF_0000) begin bad++;
      $display("FAIL top_start got %b/%h want 0001/ffff0000", core_start, core_base); end
    tick();
    total++; if (core_start !== 4'b0 || status_out !== 32'h4000_0001) begin bad++;
      $display("FAIL top_nowrap got %b/%h want 0000/40000001", core_start, status_out); end
    core_done = 4'b0001;
    tick();
    core_done = 4'b0;
    total++; if (status_out !== 32'h6000_0001) begin bad++;
      $display("FAIL top_done got %h want 60000001", status_out); end
  endtask

  task automatic test_abort();
    send(32'h2000_0000);
    send(32'h0000_0000);
    send(32'h0003_FFFF);
    send(32'h3000_0000);
    tick();
    word_valid = 1'b1;
    word_in    = 32'h7000_0000;
    #1;
    total++; if (core_start !== 4'b0010) begin bad++;
      $display("FAIL run_bad_word_start got %b want 0010", core_start); end
    tick();
    total++; if (status_out[31:27] !== 5'b01001) begin bad++;
      $display("FAIL run_err got %b want 01001", status_out[31:27]); end
    word_in = 32'h4000_0000;
    #1;
    total++; if (core_start !== 4'b0) begin bad++;
      $display("FAIL abort_no_dispatch got %b want 0000", core_start); end
    tick();
    word_valid = 1'b0;
    word_in    = '0;
    total++; if (core_abort !== 1'b1 || status_out[31:29] !== 3'd0) begin bad++;
      $display("FAIL abort_pulse got %b/%0d want 1/0", core_abort, status_out[31:29]); end
    tick();
    total++; if (core_abort !== 1'b0 || core_start !== 4'b0) begin bad++;
      $display("FAIL abort_after got %b/%b want 0/0000", core_abort, core_start); end
  endtask

  task automatic test_rst_mid_run();
    send(32'h3000_0000);
    tick();
    rst = 1'b1;
    tick();
    total++; if (status_out !== 32'h0 || target_hash !== 128'h0 || result_idx !== 32'h0)
    begin bad++;
      $display("FAIL rst_run_regs got %h/%h/%h want 0/0/0", status_out, target_hash,
               result_idx); end
    total++; if ({core_start, core_abort, has_matched} !== 6'b0) begin bad++;
      $display("FAIL rst_run_ctrl got %b want 000000", {core_start, core_abort, has_matched});
    end
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    word_valid     = 1'b0;
    word_in        = '0;
    core_done      = '0;
    core_found     = '0;
    core_found_idx = '0;
    test_reset();
    test_bad_opcode();
    test_load_hash();
    test_dispatch();
    test_found();
    test_multi_found();
    test_top_range();
    test_abort();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
